// File: rtl/imem_instr_encoder.sv
// Instruction encoder: packs RISC-V fields by immediate format, flags immediate range errors,
// and queues {instr, addr, err} in a small FIFO toward the instruction memory writer.
module imem_instr_encoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_imm_sel,
    input  logic [31:0] i_imm,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_funct7,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_addr,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [31:0]   enc_instr;
    logic          enc_err;
    logic          full, empty, push, pop;

    // Lowest set select bit wins; no bit set means R-type.
    always_comb begin
        enc_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        enc_err   = 1'b0;
        casez (i_imm_sel)
            5'b????1: begin
                enc_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_err   = !((&i_imm[31:11]) || !(|i_imm[31:11]));
            end
            5'b???10: begin
                enc_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                enc_err   = !((&i_imm[31:11]) || !(|i_imm[31:11]));
            end
            5'b??100: begin
                enc_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                enc_err   = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
            end
            5'b?1000: begin
                enc_instr = {i_imm[31:12], i_rd, i_opcode};
                enc_err   = |i_imm[11:0];
            end
            5'b10000: begin
                enc_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                enc_err   = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
            end
            default: ;
        endcase
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_ready = !full;
    assign o_valid = !empty;
    assign push    = i_valid && o_ready && !i_rst;
    assign pop     = o_valid && i_ready;

    assign addr_d    = push ? addr_q + 32'd4 : addr_q;
    assign err_cnt_d = (push && enc_err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset; pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{instr: enc_instr, addr: addr_q, err: enc_err};
    end

    assign o_instr   = mem_q[rd_ptr_q[AW-1:0]].instr;
    assign o_addr    = mem_q[rd_ptr_q[AW-1:0]].addr;
    assign o_err     = o_valid && mem_q[rd_ptr_q[AW-1:0]].err;
    assign o_err_cnt = err_cnt_q;
endmodule
